// File: rtl/stream_pkg.sv
// Shared types and default widths for the stream burst controller slice.
package stream_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } stream_state_t;

    localparam int STREAM_ADDR_W_DEF = 8;
    localparam int STREAM_LEN_W_DEF  = 8;

endpackage

// File: rtl/stream_burst_ctrl_if.sv
// Request, buffer-read and downstream stream signals of stream_burst_ctrl.
// Optional macro STREAM_BURST_CTRL_PKT_CNT_EN adds the 32-bit pkt_cnt signal.
interface stream_burst_ctrl_if
    import stream_pkg::*;
#(
    parameter int ADDR_W = STREAM_ADDR_W_DEF,
    parameter int LEN_W  = STREAM_LEN_W_DEF
);
    logic              get_fin;
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] base;
    logic              dst_ready;
    logic              dst_valid;
    logic              dst_last;
    logic              stream_v;
    logic [ADDR_W-1:0] stream_a;
    logic              busy;
    logic              pend_ovf;
`ifdef STREAM_BURST_CTRL_PKT_CNT_EN
    logic [31:0]       pkt_cnt;
`endif

    // Controller side
    modport master (
        input  get_fin, len, base, dst_ready,
        output dst_valid, dst_last, stream_v, stream_a, busy, pend_ovf
`ifdef STREAM_BURST_CTRL_PKT_CNT_EN
        , output pkt_cnt
`endif
    );

    // Requester / sink side
    modport slave (
        output get_fin, len, base, dst_ready,
        input  dst_valid, dst_last, stream_v, stream_a, busy, pend_ovf
`ifdef STREAM_BURST_CTRL_PKT_CNT_EN
        , input pkt_cnt
`endif
    );

endinterface

// File: rtl/agu_rt.sv
// Runtime-bounded beat index counter: reloads to 0 on start, advances on en,
// flags the final index when data equals fin.
module agu_rt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         en,
    input  logic [W-1:0] fin,
    output logic [W-1:0] data,
    output logic         last
);

    // Index register; a reload takes priority over an advance on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        data <= '0;
        else if (start) data <= '0;
        else if (en)    data <= data + W'(1);
    end

    assign last = (data == fin);

endmodule

// File: rtl/stream_burst_ctrl.sv
// Burst read-address generator with valid/last handshake toward a stream sink.
// One request may wait in a pending slot so bursts run back-to-back.
// Optional macro STREAM_BURST_CTRL_PKT_CNT_EN adds a completed-burst counter.
module stream_burst_ctrl
    import stream_pkg::*;
#(
    parameter int ADDR_W = STREAM_ADDR_W_DEF,
    parameter int LEN_W  = STREAM_LEN_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    stream_burst_ctrl_if.master bus
);

    stream_state_t     state, state_nxt;
    logic [ADDR_W-1:0] cur_base;
    logic [LEN_W-1:0]  cur_len;
    logic [LEN_W-1:0]  i;
    logic              i_last;
    logic              pend_v;
    logic [ADDR_W-1:0] pend_base;
    logic [LEN_W-1:0]  pend_len;
    logic              dst_valid_q;
    logic              dst_last_q;
    logic              pend_ovf_q;
    logic              stream_v;
    logic              last_issue;
    logic              load_act;
    logic              load_from_pend;
    logic              pend_set;
    logic              pend_clr;
    logic              ovf_set;

    assign stream_v   = (state == STREAM) & bus.dst_ready;
    assign last_issue = stream_v & i_last;

    agu_rt #(.W(LEN_W)) u_agu (
        .clk   (clk),
        .rst   (rst),
        .start (load_act),
        .en    (stream_v),
        .fin   (cur_len),
        .data  (i),
        .last  (i_last)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state, active-register load and pending-slot control
    always_comb begin
        state_nxt      = state;
        load_act       = 1'b0;
        load_from_pend = 1'b0;
        pend_set       = 1'b0;
        pend_clr       = 1'b0;
        ovf_set        = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.get_fin) begin
                    load_act  = 1'b1;
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (last_issue) begin
                    if (pend_v) begin
                        // Slot drains into the active registers and is refilled
                        // by a same-edge request, so this case never overflows.
                        load_act       = 1'b1;
                        load_from_pend = 1'b1;
                        pend_set       = bus.get_fin;
                        pend_clr       = ~bus.get_fin;
                    end else if (bus.get_fin) begin
                        load_act = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (bus.get_fin) begin
                    if (!pend_v) pend_set = 1'b1;
                    else         ovf_set  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Active burst registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_base <= '0;
            cur_len  <= '0;
        end else if (load_act) begin
            cur_base <= load_from_pend ? pend_base : bus.base;
            cur_len  <= load_from_pend ? pend_len  : bus.len;
        end
    end

    // One-deep pending request slot and sticky overflow flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_v     <= 1'b0;
            pend_base  <= '0;
            pend_len   <= '0;
            pend_ovf_q <= 1'b0;
        end else begin
            if (pend_set) begin
                pend_v    <= 1'b1;
                pend_base <= bus.base;
                pend_len  <= bus.len;
            end else if (pend_clr) begin
                pend_v <= 1'b0;
            end
            if (ovf_set) pend_ovf_q <= 1'b1;
        end
    end

    // Output beat registers; hold while downstream is not ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dst_valid_q <= 1'b0;
            dst_last_q  <= 1'b0;
        end else if (bus.dst_ready) begin
            dst_valid_q <= stream_v;
            dst_last_q  <= last_issue;
        end
    end

`ifdef STREAM_BURST_CTRL_PKT_CNT_EN
    logic [31:0] pkt_cnt_q;

    // Completed-burst counter, counts accepted final beats
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                           pkt_cnt_q <= '0;
        else if (dst_valid_q & dst_last_q & bus.dst_ready) pkt_cnt_q <= pkt_cnt_q + 32'd1;
    end

    assign bus.pkt_cnt = pkt_cnt_q;
`endif

    assign bus.stream_v  = stream_v;
    assign bus.stream_a  = cur_base + ADDR_W'(i);
    assign bus.dst_valid = dst_valid_q;
    assign bus.dst_last  = dst_last_q;
    assign bus.busy      = (state == STREAM) | dst_valid_q;
    assign bus.pend_ovf  = pend_ovf_q;

endmodule
